// File: rtl/isa_pkg.sv
// ============================================================================
//  Module      : isa_pkg
//  Description : Team ISA opcodes, funct codes and control-word layout shared
//                by the instruction encoder/loader and its encoder stage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package isa_pkg;

    localparam logic [5:0] OP_R  = 6'b000001;
    localparam logic [5:0] OP_LW = 6'b000010;
    localparam logic [5:0] OP_SW = 6'b000011;

    localparam logic [5:0] F_NOP = 6'd31;
    localparam logic [5:0] F_ADD = 6'd32;
    localparam logic [5:0] F_SUB = 6'd34;
    localparam logic [5:0] F_AND = 6'd36;
    localparam logic [5:0] F_OR  = 6'd37;
    localparam logic [5:0] F_MUL = 6'd50;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_e;

    localparam int CW_W       = 21;
    localparam int CW_RSA_LSB = 16;
    localparam int CW_RSB_LSB = 11;
    localparam int CW_RD_LSB  = 6;
    localparam int CW_BIMM    = 5;
    localparam int CW_MUL     = 4;
    localparam int CW_MWR     = 3;
    localparam int CW_WBM     = 2;
    localparam int CW_OP_LSB  = 0;

    typedef struct packed {
        logic [4:0] rs_a;
        logic [4:0] rs_b;
        logic [4:0] rd;
        logic       b_imm;
        logic       alu_mul;
        logic       mem_wr;
        logic       wb_mem;
        alu_op_e    alu_op;
    } ctrl_word_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    function automatic ctrl_word_t unpack_ctrl(input logic [CW_W-1:0] raw);
        ctrl_word_t cw;
        cw.rs_a    = raw[CW_RSA_LSB +: 5];
        cw.rs_b    = raw[CW_RSB_LSB +: 5];
        cw.rd      = raw[CW_RD_LSB +: 5];
        cw.b_imm   = raw[CW_BIMM];
        cw.alu_mul = raw[CW_MUL];
        cw.mem_wr  = raw[CW_MWR];
        cw.wb_mem  = raw[CW_WBM];
        cw.alu_op  = alu_op_e'(raw[CW_OP_LSB +: 2]);
        return cw;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ctrl_to_instr.sv
// ============================================================================
//  Module      : ctrl_to_instr
//  Description : Combinational re-encoder from a 21-bit control word plus
//                immediate to a 32-bit instruction; flags illegal words.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ctrl_to_instr
    import isa_pkg::*;
#(
    parameter int SHAMT_DEF = 10
) (
    input  logic [CW_W-1:0] i_ctrl,
    input  logic [15:0]     i_imm,
    output logic [31:0]     o_instr,
    output logic            o_illegal
);

    localparam logic [4:0] c_shamt = 5'(SHAMT_DEF);

    ctrl_word_t w_cw;
    logic [5:0] w_funct;
    logic       w_funct_ok;

    assign w_cw = unpack_ctrl(i_ctrl);

    // R-type function code; a multiply is only legal with the ADD alu_op
    always_comb begin
        w_funct    = F_NOP;
        w_funct_ok = 1'b1;
        if (w_cw.alu_mul) begin
            w_funct    = F_MUL;
            w_funct_ok = (w_cw.alu_op == ALU_ADD);
        end else begin
            case (w_cw.alu_op)
                ALU_ADD: w_funct = F_ADD;
                ALU_SUB: w_funct = F_SUB;
                ALU_AND: w_funct = F_AND;
                ALU_OR:  w_funct = F_OR;
                default: w_funct = F_NOP;
            endcase
        end
    end

    always_comb begin
        o_instr   = {OP_R, 15'd0, c_shamt, F_NOP};
        o_illegal = 1'b1;
        if (!w_cw.b_imm && !w_cw.mem_wr && !w_cw.wb_mem) begin
            o_illegal = (i_ctrl != '0);
        end else if (w_cw.b_imm && !w_cw.mem_wr && !w_cw.wb_mem) begin
            if (w_funct_ok) begin
                o_instr   = {OP_R, w_cw.rs_a, w_cw.rs_b, w_cw.rd, c_shamt, w_funct};
                o_illegal = 1'b0;
            end
        end else if (!w_cw.b_imm && w_cw.wb_mem && !w_cw.mem_wr && !w_cw.alu_mul &&
                     w_cw.alu_op == ALU_ADD && w_cw.rs_b == 5'd0) begin
            o_instr   = {OP_LW, w_cw.rs_a, w_cw.rd, i_imm};
            o_illegal = 1'b0;
        end else if (!w_cw.b_imm && w_cw.mem_wr && !w_cw.wb_mem && !w_cw.alu_mul &&
                     w_cw.alu_op == ALU_ADD && w_cw.rd == 5'd0) begin
            o_instr   = {OP_SW, w_cw.rs_a, w_cw.rs_b, i_imm};
            o_illegal = 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/instr_encoder_loader.sv
// ============================================================================
//  Module      : instr_encoder_loader
//  Description : Accepts control words over valid/ready, encodes them and
//                writes them sequentially into instruction memory.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_encoder_loader
    import isa_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int DEPTH     = 256,
    parameter int SHAMT_DEF = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CW_W-1:0]   in_ctrl,
    input  logic [15:0]       in_imm,
    input  logic              in_last,
    output logic              imem_we,
    input  logic              imem_ready,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done,
    output logic              illegal,
    output logic              overflow
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] c_depth    = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_last_idx = CNT_W'(DEPTH - 1);

    state_e            state_q,    state_d;
    logic [CNT_W-1:0]  acc_q,      acc_d;
    logic [CNT_W-1:0]  count_q,    count_d;
    logic              we_q,       we_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic [31:0]       wdata_q,    wdata_d;
    logic              done_q,     done_d;
    logic              illegal_q,  illegal_d;
    logic              overflow_q, overflow_d;

    logic [31:0] w_instr;
    logic        w_illegal;
    logic        w_we;
    logic        w_wr_done;
    logic        w_in_ready;
    logic        w_accept;

    ctrl_to_instr #(
        .SHAMT_DEF (SHAMT_DEF)
    ) u_enc (
        .i_ctrl    (in_ctrl),
        .i_imm     (in_imm),
        .o_instr   (w_instr),
        .o_illegal (w_illegal)
    );

    // start discards the held word immediately, so the write strobe is gated
    // combinationally and no word is taken on the restart cycle
    assign w_we       = we_q && !start;
    assign w_wr_done  = w_we && imem_ready;
    assign w_in_ready = (state_q == ST_LOAD) && (acc_q < c_depth) &&
                        (!w_we || imem_ready) && !start;
    assign w_accept   = in_valid && w_in_ready;

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        count_d    = count_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        done_d     = done_q;
        illegal_d  = illegal_q;
        overflow_d = overflow_q;

        if (w_wr_done) begin
            we_d = 1'b0;
            if (count_q < c_depth) begin
                count_d = count_q + 1'b1;
            end
        end

        if (w_accept) begin
            we_d    = 1'b1;
            addr_d  = acc_q[ADDR_W-1:0];
            wdata_d = w_instr;
            acc_d   = acc_q + 1'b1;
            if (w_illegal) begin
                illegal_d = 1'b1;
            end
            if (in_last || acc_q == c_last_idx) begin
                state_d = ST_DRAIN;
            end
        end

        case (state_q)
            ST_LOAD: begin
                if (in_valid && acc_q >= c_depth) begin
                    overflow_d = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (in_valid) begin
                    overflow_d = 1'b1;
                end
                if (!we_q || w_wr_done) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: ;
        endcase

        if (start) begin
            state_d    = ST_LOAD;
            acc_d      = '0;
            count_d    = '0;
            we_d       = 1'b0;
            addr_d     = '0;
            wdata_d    = '0;
            done_d     = 1'b0;
            illegal_d  = 1'b0;
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            acc_q      <= '0;
            count_q    <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            done_q     <= 1'b0;
            illegal_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            count_q    <= count_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            done_q     <= done_d;
            illegal_q  <= illegal_d;
            overflow_q <= overflow_d;
        end
    end

    assign in_ready   = w_in_ready;
    assign imem_we    = w_we;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign count      = count_q;
    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;
    assign illegal    = illegal_q;
    assign overflow   = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder_loader.sv
// ============================================================================
//  Module      : tb_instr_encoder_loader
//  Description : Scoreboard bench for instr_encoder_loader (DEPTH=4 build).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_encoder_loader;

    localparam int ADDR_W = 3;
    localparam int DEPTH  = 4;
    localparam int SHAMT  = 10;

    logic              clk = 1'b0;
    logic              rst, start, in_valid, in_last, imem_ready;
    logic [20:0]       in_ctrl;
    logic [15:0]       in_imm;
    logic              in_ready, imem_we, busy, done, illegal, overflow;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [ADDR_W:0]   count;

    always #5 clk = ~clk;

    instr_encoder_loader #(
        .ADDR_W    (ADDR_W),
        .DEPTH     (DEPTH),
        .SHAMT_DEF (SHAMT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_ctrl    (in_ctrl),
        .in_imm     (in_imm),
        .in_last    (in_last),
        .imem_we    (imem_we),
        .imem_ready (imem_ready),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .count      (count),
        .busy       (busy),
        .done       (done),
        .illegal    (illegal),
        .overflow   (overflow)
    );

    typedef struct {
        int          addr;
        logic [31:0] data;
        bit          legal;
        logic [20:0] ctrl;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   written = 0;
    int   idx = 0;
    bit   exp_ill = 0;
    bit   exp_ovf = 0;
    int   ready_mode = 1;
    int   hold_low = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: actual=timeout expected=event", name);
    endtask

    // Reference encoding from the ISA table: fields in, instruction word out
    function automatic void model(input logic [20:0] c, input logic [15:0] imm,
                                  output logic [31:0] w, output bit legal);
        int rsa, rsb, rd, bimm, mul, mwr, wbm, op, f;
        rsa  = int'(c >> 16) % 32;
        rsb  = int'(c >> 11) % 32;
        rd   = int'(c >> 6) % 32;
        bimm = int'(c >> 5) % 2;
        mul  = int'(c >> 4) % 2;
        mwr  = int'(c >> 3) % 2;
        wbm  = int'(c >> 2) % 2;
        op   = int'(c) % 4;
        legal = 0;
        w = 32'(1 * 2**26 + SHAMT * 64 + 31);
        f = -1;
        if (c == 0) begin
            legal = 1;
        end else if (bimm == 1 && mwr == 0 && wbm == 0) begin
            if (mul == 1) f = (op == 0) ? 50 : -1;
            else          f = (op == 0) ? 32 : (op == 1) ? 34 : (op == 2) ? 36 : 37;
            if (f >= 0) begin
                legal = 1;
                w = 32'(1 * 2**26 + rsa * 2**21 + rsb * 2**16 + rd * 2**11 + SHAMT * 64 + f);
            end
        end else if (bimm == 0 && wbm == 1 && mwr == 0 && mul == 0 && op == 0 && rsb == 0) begin
            legal = 1;
            w = 32'(2 * 2**26 + rsa * 2**21 + rd * 2**16 + int'(imm));
        end else if (bimm == 0 && mwr == 1 && wbm == 0 && mul == 0 && op == 0 && rd == 0) begin
            legal = 1;
            w = 32'(3 * 2**26 + rsa * 2**21 + rsb * 2**16 + int'(imm));
        end
    endfunction

    // Decoder view of an instruction, used for the round-trip property
    function automatic logic [20:0] decode(input logic [31:0] w);
        int opc, f, rsa, rsb, rd, c;
        opc = int'(w >> 26);
        f   = int'(w % 64);
        rsa = int'((w >> 21) % 32);
        rsb = int'((w >> 16) % 32);
        rd  = int'((w >> 11) % 32);
        c   = 0;
        if (opc == 1 && f != 31) begin
            c = rsa * 65536 + rsb * 2048 + rd * 64 + 32;
            if (f == 50)      c += 16;
            else if (f == 34) c += 1;
            else if (f == 36) c += 2;
            else if (f == 37) c += 3;
        end else if (opc == 2) begin
            c = rsa * 65536 + rsb * 64 + 4;
        end else if (opc == 3) begin
            c = rsa * 65536 + rsb * 2048 + 8;
        end
        return 21'(c);
    endfunction

    function automatic logic [20:0] rand_ctrl(input bit legal_only);
        int k, rsa, rsb, rd, op;
        k   = legal_only ? $urandom_range(0, 4) : $urandom_range(0, 5);
        rsa = $urandom_range(0, 31);
        rsb = $urandom_range(0, 31);
        rd  = $urandom_range(0, 31);
        op  = $urandom_range(0, 3);
        case (k)
            0:       return 21'd0;
            1:       return 21'(rsa * 65536 + rsb * 2048 + rd * 64 + 32 + op);
            2:       return 21'(rsa * 65536 + rsb * 2048 + rd * 64 + 32 + 16);
            3:       return 21'(rsa * 65536 + rd * 64 + 4);
            4:       return 21'(rsa * 65536 + rsb * 2048 + 8);
            default: return 21'($urandom % (1 << 21));
        endcase
    endfunction

    // Memory-side ready: random, forced high/low, or a counted stall burst
    initial begin
        imem_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (hold_low > 0) begin
                imem_ready = 1'b0;
                hold_low--;
            end else if (ready_mode == 1) imem_ready = 1'b1;
            else if (ready_mode == 2)    imem_ready = 1'b0;
            else                          imem_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: pops the scoreboard on every completed write
    initial begin
        exp_t              e;
        bit                prev_stall;
        logic [ADDR_W-1:0] prev_addr;
        logic [31:0]       prev_data;
        prev_stall = 0;
        prev_addr  = '0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 0;
            end else if (start) begin
                check("we_during_start", imem_we, 0);
                prev_stall = 0;
            end else begin
                if (prev_stall) begin
                    check("hold_we", imem_we, 1);
                    check("hold_addr", imem_addr, prev_addr);
                    check("hold_data", imem_wdata, prev_data);
                end
                if (imem_we && !imem_ready) check("in_ready_in_stall", in_ready, 0);
                check("count_running", count, written);
                if (imem_we && imem_ready) begin
                    if (sb_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL spurious_write: actual addr=%0h data=%0h required=no write",
                                 imem_addr, imem_wdata);
                    end else begin
                        e = sb_q.pop_front();
                        check("wr_addr", imem_addr, e.addr);
                        check("wr_data", imem_wdata, e.data);
                        if (e.legal) check("round_trip", decode(imem_wdata), e.ctrl);
                    end
                    written++;
                end
                prev_stall = imem_we && !imem_ready;
                prev_addr  = imem_addr;
                prev_data  = imem_wdata;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_model();
        sb_q.delete();
        written = 0;
        idx     = 0;
        exp_ill = 0;
        exp_ovf = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        in_last = 1'b0;
        tick();
        reset_model();
        tick();
        rst = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        reset_model();
    endtask

    task automatic send_word(input logic [20:0] c, input logic [15:0] imm, input bit last);
        logic [31:0] w;
        bit          legal;
        in_valid = 1'b1;
        in_ctrl  = c;
        in_imm   = imm;
        in_last  = last;
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk);
            if (in_ready) begin
                model(c, imm, w, legal);
                sb_q.push_back('{idx, w, legal, c});
                idx++;
                if (!legal) exp_ill = 1;
                tick();
                return;
            end
            tick();
        end
        fail_now("accept_timeout");
    endtask

    task automatic finish_session();
        int k;
        k = 0;
        @(negedge clk);
        while (busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("busy_end", busy, 0);
        check("done_end", done, 1);
        check("count_end", count, idx);
        check("illegal_end", illegal, exp_ill);
        check("overflow_end", overflow, exp_ovf);
        check("all_written", sb_q.size(), 0);
        tick();
    endtask

    task automatic rand_session();
        int n;
        bit extra, last;
        n     = $urandom_range(1, DEPTH);
        extra = ($urandom_range(0, 3) == 0);
        do_start();
        for (int i = 0; i < n; i++) begin
            last = (i == n - 1) && (n < DEPTH || $urandom_range(0, 1) == 1);
            send_word(rand_ctrl(0), 16'($urandom), last);
            if (i < n - 1 && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) tick();
            end
        end
        if (extra) begin
            exp_ovf = 1;
            repeat (2) tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        finish_session();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual=still running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_ctrl = '0; in_imm = '0;
        do_reset();
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_we", imem_we, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_illegal", illegal, 0);
        check("rst_overflow", overflow, 0);
        check("rst_addr", imem_addr, 0);
        check("rst_wdata", imem_wdata, 0);
        check("rst_count", count, 0);
        tick();

        // SUB r3 = r1 - r2
        ready_mode = 1;
        do_start();
        send_word(21'h110E1, 16'h0000, 1'b1);
        in_valid = 1'b0;
        @(negedge clk);
        check("sub_we", imem_we, 1);
        check("sub_addr", imem_addr, 0);
        check("sub_wdata", imem_wdata, 32'h04221AA2);
        tick();
        finish_session();

        // LW r5, 0x10(r4)
        do_start();
        send_word(21'h40144, 16'h0010, 1'b1);
        in_valid = 1'b0;
        @(negedge clk);
        check("lw_wdata", imem_wdata, 32'h08850010);
        tick();
        finish_session();

        // valid while idle is ignored
        in_valid = 1'b1;
        in_ctrl  = rand_ctrl(1);
        repeat (3) tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("idle_overflow", overflow, 0);
        check("idle_count", count, 1);
        tick();

        // four words with a three-cycle memory stall on the second
        do_start();
        for (int i = 0; i < 4; i++) begin
            send_word(rand_ctrl(1), 16'($urandom), 1'b0);
            if (i == 1) hold_low = 3;
        end
        in_valid = 1'b0;
        finish_session();

        // six words offered to a four-deep session
        do_start();
        for (int i = 0; i < 4; i++) send_word(rand_ctrl(1), 16'($urandom), 1'b0);
        exp_ovf = 1;
        in_ctrl = rand_ctrl(1);
        repeat (2) tick();
        in_valid = 1'b0;
        finish_session();

        // illegal word encodes as NOP and sets a sticky flag
        do_start();
        send_word(21'h00028, 16'h1234, 1'b1);
        in_valid = 1'b0;
        @(negedge clk);
        check("ill_wdata", imem_wdata, 32'h0400029F);
        tick();
        finish_session();
        repeat (3) tick();
        @(negedge clk);
        check("ill_sticky", illegal, 1);
        tick();
        do_start();
        @(negedge clk);
        check("ill_cleared", illegal, 0);
        check("done_cleared", done, 0);
        tick();

        // restart while a write is stalled
        ready_mode = 2;
        send_word(rand_ctrl(1), 16'($urandom), 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        check("stalled_we", imem_we, 1);
        tick();
        start = 1'b1;
        @(negedge clk);
        check("start_drops_we", imem_we, 0);
        tick();
        start = 1'b0;
        reset_model();
        ready_mode = 1;
        @(negedge clk);
        check("restart_count", count, 0);
        tick();
        send_word(rand_ctrl(1), 16'($urandom), 1'b1);
        in_valid = 1'b0;
        finish_session();

        // reset while a write is stalled
        ready_mode = 2;
        do_start();
        send_word(rand_ctrl(1), 16'($urandom), 1'b0);
        in_valid = 1'b0;
        tick();
        do_reset();
        @(negedge clk);
        check("midrst_we", imem_we, 0);
        check("midrst_busy", busy, 0);
        check("midrst_count", count, 0);
        check("midrst_wdata", imem_wdata, 0);
        tick();
        ready_mode = 1;
        do_start();
        send_word(rand_ctrl(1), 16'($urandom), 1'b1);
        in_valid = 1'b0;
        finish_session();

        ready_mode = 0;
        repeat (30) rand_session();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Inverse of the instruction decoder. Accepts 21-bit control words plus a 16-bit immediate over a valid/ready stream.
- Re-encodes each word into a 32-bit instruction in the team ISA format.
- Writes the instructions sequentially into instruction memory through a stall-able write port.
- Used for program loading and for round-trip checking against the decoder.

Parameters:
- ADDR_W, 8, instruction memory word-address width.
- DEPTH, 256, maximum words per load session; must be ≤ 2**ADDR_W.
- SHAMT_DEF, 10, value placed in bits [10:6] of every R-type word.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse: begin a new load session at address 0.
- in_valid  in  1  control word present.
- in_ready  out  1  block accepts a word this cycle.
- in_ctrl  in  21  control word. Fields: [20:16] rsA, [15:11] rsB, [10:6] rd, [5] b_imm, [4] alu_mul, [3] mem_wr, [2] wb_mem, [1:0] alu_op.
- in_imm  in  16  immediate for load/store words.
- in_last  in  1  marks the final word of the program.
- imem_we  out  1  write request.
- imem_ready  in  1  memory accepts the write this cycle.
- imem_addr  out  ADDR_W  write address.
- imem_wdata  out  32  encoded instruction.
- count  out  ADDR_W+1  words committed this session.
- busy  out  1  session in progress.
- done  out  1  session finished (sticky until start or rst).
- illegal  out  1  sticky: an illegal control word was seen this session.
- overflow  out  1  sticky: in_valid asserted while the session was full.

Behaviour:
- Reset: state IDLE. in_ready, imem_we, busy, done, illegal and overflow are 0. imem_addr = 0, imem_wdata = 0, count = 0.
- FSM has three states: IDLE, LOAD, DRAIN.
  - IDLE: start → LOAD. Clears count, done, illegal, overflow and the output register.
  - LOAD: accepts words.
    - Accepting a word with in_last=1 → DRAIN.
    - Accepting word number DEPTH → DRAIN.
  - DRAIN: when the output register empties → IDLE, with done=1.
- start in LOAD or DRAIN restarts the session on that cycle. Any pending unwritten word is discarded and imem_we drops the same cycle.
- busy = (state != IDLE).
- Handshake:
  - in_ready = (state==LOAD) && (count_accepted < DEPTH) && (!imem_we || imem_ready).
  - A transfer occurs when in_valid && in_ready.
- Latency: one cycle. The encoded word is registered, and imem_we is asserted the cycle after acceptance.
  - imem_we, imem_addr and imem_wdata hold stable until imem_ready=1.
  - One-entry pipeline: a new word may be accepted in the same cycle the held word is written. Full throughput is one word per cycle while imem_ready=1.
- imem_addr = the index of the word, counting from 0.
- count increments on each completed write (imem_we && imem_ready). It wraps never; it saturates at DEPTH.
- Encoding (opcode field = bits [31:26], funct = bits [5:0]):
  - NOP: b_imm=0, mem_wr=0, wb_mem=0. All other fields must be 0.
    - Output: opcode 6'b000001, funct 31, shamt SHAMT_DEF, register fields 0.
  - R-type: b_imm=1, mem_wr=0, wb_mem=0.
    - Output: opcode 6'b000001, [25:21]=rsA, [20:16]=rsB, [15:11]=rd, [10:6]=SHAMT_DEF.
    - funct when alu_mul=1: 50, and alu_op must be 00.
    - funct when alu_mul=0: alu_op 00→32, 01→34, 10→36, 11→37.
  - LW: b_imm=0, wb_mem=1, mem_wr=0, alu_mul=0, alu_op=00, rsB=0.
    - Output: opcode 6'b000010, [25:21]=rsA, [20:16]=rd, [15:0]=in_imm.
  - SW: b_imm=0, mem_wr=1, wb_mem=0, alu_mul=0, alu_op=00, rd=0.
    - Output: opcode 6'b000011, [25:21]=rsA, [20:16]=rsB, [15:0]=in_imm.
  - Any other combination is illegal. It is encoded as NOP, still written and counted, and sets illegal.
- Round-trip property: for every legal word, decoding the encoded instruction returns the original in_ctrl.
- Boundaries:
  - in_valid while in LOAD and full, or while in DRAIN: not accepted, and sets overflow.
  - in_valid in IDLE: ignored, no flag set.
  - in_last on word DEPTH: treated as a single termination.
  - rst mid-session: immediate return to reset values; the pending write is dropped.

Decomposition:
- Shared package isa_pkg:
  - opcode constants OP_R=6'b000001, OP_LW=6'b000010, OP_SW=6'b000011.
  - funct constants F_NOP=31, F_ADD=32, F_SUB=34, F_AND=36, F_OR=37, F_MUL=50.
  - ALU op encodings.
  - Control-word field bit positions.
  - A packed struct type for the 21-bit control word.
- Sub-module ctrl_to_instr: purely combinational encoder, outputs {instr[31:0], illegal}. The FSM, handshake and counters stay in the top.

Test Plan:
- Reset, then start, then one word with in_ctrl={1,2,3,1,0,0,0,2'b01}.
  - Expect: next cycle imem_we=1, addr 0, wdata = 32'h04221a a2 (opcode 1, rs 1, rt 2, rd 3, shamt 10, funct 34).
- LW rsA=4, rd=5, in_imm=16'h0010, with in_last=1.
  - Expect: wdata = 32'h08850010; then done=1, busy=0, count=1.
- Stream 4 words back-to-back with imem_ready low for 3 cycles on word 2.
  - Expect: in_ready drops; words written in order to addresses 0–3 with data unchanged; count=4.
- DEPTH=4 build: offer 6 words with no in_last.
  - Expect: exactly 4 written; overflow=1; done=1.
- Illegal word (b_imm=1, mem_wr=1).
  - Expect: NOP 32'h0400029f written; illegal=1; sticky until the next start.
- Assert start while a write is stalled by imem_ready=0.
  - Expect: imem_we=0 the same cycle, count=0, next accepted word goes to address 0. Repeat the check with rst in place of start.
